toggle_timer: RTL and testbench
===============================

TOGGLE_TIMER -- requirements
Module: toggle_timer

Interface
REQ-001 Parameters SHALL be one per line:
- DELAY_TIME, default 1000, wait limit in clk_slow cycles, legal range 0..2^CNT_W-1.
- CNT_W, default 16, counter width, requires 2^CNT_W > DELAY_TIME.
REQ-002 Ports SHALL be one per line, clock and reset first:
- clk_slow  input  1  block clock, rising-edge active.
- i_RST  input  1  reset, asynchronous, active-high.
- o_CTR  output  1  toggling control/LED output.
- o_OVERFLOW  output  1  counter-reached-limit flag.
- o_STATE  output  2  current FSM state, for debug.
- o_CNT  output  CNT_W  current counter value, for debug.
REQ-003 Reset SHALL be i_RST, asynchronous, active-high; clock SHALL be clk_slow; all state SHALL be updated on rising clk_slow only, with no dual-edge logic.

Function
REQ-004 The FSM SHALL have exactly three states, encoded ST_RST=2'b00, ST_WAIT=2'b01, ST_CHANGE=2'b10.
REQ-005 ST_RST SHALL last one cycle, clear the counter to 0, and go to ST_WAIT.
REQ-006 In ST_WAIT the counter SHALL increment by 1 per cycle while cnt < DELAY_TIME and SHALL saturate at DELAY_TIME.
REQ-007 o_OVERFLOW SHALL be combinational, equal to (state==ST_WAIT) && (cnt==DELAY_TIME).
REQ-008 In ST_WAIT with o_OVERFLOW=1, the next edge SHALL go to ST_CHANGE and toggle o_CTR on that same edge.
REQ-009 ST_CHANGE SHALL last one cycle, hold the counter and o_CTR, and go to ST_RST.
REQ-010 o_CTR SHALL be a register, changing only on the WAIT->CHANGE edge; the period between toggles SHALL be DELAY_TIME+3 cycles.
REQ-011 DELAY_TIME=0 SHALL be legal: WAIT lasts one cycle, giving a toggle period of 3 cycles.
REQ-012 Illegal state 2'b11 SHALL go to ST_RST on the next edge, with o_CTR held and the counter cleared there.
REQ-013 The counter SHALL not change in ST_CHANGE and SHALL not wrap.

Reset
REQ-014 While i_RST=1: state=ST_RST, cnt=0, o_CTR=0, o_OVERFLOW=0, applied immediately with no clock edge required.
REQ-015 Reset asserted mid-operation (any state, any cnt) SHALL abort the current interval; after release the sequence SHALL restart from ST_RST with o_CTR=0.
REQ-016 The first rising edge after release SHALL perform the ST_RST actions; the first toggle SHALL occur on edge DELAY_TIME+2 after release.

Structure
REQ-017 A shared package SHALL hold the state encodings ST_RST/ST_WAIT/ST_CHANGE and the default DELAY_TIME.
REQ-018 The saturating counter plus its overflow compare SHALL be one sub-module, limit_counter, with ports: clock, async reset, synchronous clear, enable, limit, count, overflow.
REQ-019 The top level SHALL contain the FSM, the o_CTR register, and one limit_counter instance; there SHALL be no clock dividers or derived clocks inside the block.

Verification
REQ-020 Use DELAY_TIME=4. Release reset, count edges -> o_CTR 0->1 at edge 6, 1->0 at edge 13, 0->1 at edge 20.
REQ-021 Use DELAY_TIME=4. Monitor o_OVERFLOW -> it is high for exactly one cycle (cnt=4, ST_WAIT) before each toggle, and low otherwise.
REQ-022 Use DELAY_TIME=4. Assert i_RST asynchronously mid-ST_WAIT at cnt=2 with o_CTR=1 -> o_CTR=0, cnt=0, o_STATE=00 immediately; after release, the first toggle is at edge 6.
REQ-023 Use DELAY_TIME=0 -> o_CTR toggles every 3 cycles, with the state sequence 00,01,10 repeating.
REQ-024 Force the state to 2'b11 -> the next edge gives o_STATE=00 with o_CTR unchanged; normal period resumes thereafter.
REQ-025 Use the default DELAY_TIME=1000 -> toggles 1003 cycles apart, and cnt never exceeds 1000.

Source files
------------

// File: rtl/toggle_timer_pkg.sv
// toggle_timer_pkg: shared FSM encodings and default timing for toggle_timer
//   ST_RST / ST_WAIT / ST_CHANGE : FSM state encodings
//   DEFAULT_DELAY_TIME           : default wait limit in clk_slow cycles
//   DEFAULT_CNT_W                : default counter width
package toggle_timer_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'b00,
        ST_WAIT   = 2'b01,
        ST_CHANGE = 2'b10
    } state_e;

    localparam int DEFAULT_DELAY_TIME = 1000;
    localparam int DEFAULT_CNT_W      = 16;

endpackage

// File: rtl/toggle_timer_limit_counter.sv
// limit_counter: saturating up-counter with limit compare
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears count
//   clr      : synchronous clear, wins over enable
//   en       : count enable; also qualifies overflow
//   limit    : saturation value
//   cnt      : current count
//   overflow : en && cnt == limit (combinational)
module limit_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : (en && cnt_q < limit) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt      = cnt_q;
    assign overflow = en && (cnt_q == limit);

endmodule

// File: rtl/toggle_timer.sv
// toggle_timer: toggles o_CTR every DELAY_TIME+3 clk_slow cycles
//   clk_slow   : rising-edge clock
//   i_RST      : asynchronous active-high reset
//   o_CTR      : registered toggling control/LED output
//   o_OVERFLOW : high while waiting with the counter at its limit
//   o_STATE    : current FSM state (debug)
//   o_CNT      : current counter value (debug)
module toggle_timer
    import toggle_timer_pkg::*;
#(
    parameter int DELAY_TIME = DEFAULT_DELAY_TIME,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic             clk_slow,
    input  logic             i_RST,
    output logic             o_CTR,
    output logic             o_OVERFLOW,
    output logic [1:0]       o_STATE,
    output logic [CNT_W-1:0] o_CNT
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DELAY_TIME);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             ctr_q;
    logic             ctr_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_slow or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_RST;
            ctr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // CHANGE and the unused encoding 2'b11 both fall back to ST_RST
    always_comb begin
        state_d = (state_q == ST_RST)  ? ST_WAIT :
                  (state_q == ST_WAIT) ? (ovf ? ST_CHANGE : ST_WAIT) :
                                         ST_RST;
        ctr_d   = ctr_q ^ ovf;
    end

    // Counter clears in ST_RST and in the illegal state; only counts in ST_WAIT
    always_comb begin
        cnt_clr    = (state_q != ST_WAIT) && (state_q != ST_CHANGE);
        cnt_en     = (state_q == ST_WAIT);
        o_CTR      = ctr_q;
        o_OVERFLOW = ovf;
        o_STATE    = state_q;
        o_CNT      = cnt;
    end

    limit_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk_slow),
        .rst     (i_RST),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (LIMIT),
        .cnt     (cnt),
        .overflow(ovf)
    );

endmodule

// File: tb/tb_toggle_timer.sv
// tb_toggle_timer: table-driven and directed checks of toggle_timer for DELAY_TIME 4, 0 and 1000
module tb_toggle_timer;

    logic        clk_slow = 1'b0;
    logic        rst      = 1'b1;
    logic        ctr4, ovf4, ctr0, ovf0, ctrd, ovfd;
    logic [1:0]  st4, st0, std;
    logic [15:0] cnt4, cnt0, cntd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_slow = ~clk_slow;

    toggle_timer #(.DELAY_TIME(4), .CNT_W(16)) dut4 (
        .clk_slow(clk_slow), .i_RST(rst), .o_CTR(ctr4), .o_OVERFLOW(ovf4), .o_STATE(st4), .o_CNT(cnt4));
    toggle_timer #(.DELAY_TIME(0), .CNT_W(16)) dut0 (
        .clk_slow(clk_slow), .i_RST(rst), .o_CTR(ctr0), .o_OVERFLOW(ovf0), .o_STATE(st0), .o_CNT(cnt0));
    toggle_timer dutd (
        .clk_slow(clk_slow), .i_RST(rst), .o_CTR(ctrd), .o_OVERFLOW(ovfd), .o_STATE(std), .o_CNT(cntd));

    typedef struct {
        logic       rst;
        logic       ctr;
        logic       ovf;
        logic [1:0] st;
        int         cnt;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ctr_of(input int sel);
        return (sel == 0) ? ctr4 : (sel == 1) ? ctr0 : ctrd;
    endfunction

    // Edges until the selected o_CTR changes; -1 if the budget runs out
    task automatic edges_to_toggle(input int sel, input int budget, output int n);
        logic c0;
        c0 = ctr_of(sel);
        n  = 0;
        while (n >= 0) begin
            @(posedge clk_slow);
            #1;
            n++;
            if (ctr_of(sel) != c0) break;
            if (n >= budget) n = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_slow);
        rst = 1'b0;
    endtask

    int         n;
    int         first_e, second_e, maxc;
    logic       prev, c_hold;
    logic [1:0] exp_st;

    initial begin
        // DELAY_TIME=4 reference sequence: step 0 under reset, steps 1..20 are edges after release
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b01, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b01, 3};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 4};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'b10, 4};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'b01, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b01, 3};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 2'b01, 4};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b10, 4};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 4};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 2'b01, 0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 2'b01, 1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b01, 2};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 2'b01, 3};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 2'b01, 4};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 2'b10, 4};

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst;
            @(negedge clk_slow);
            chk($sformatf("d4_ctr[%0d]", i), 32'(ctr4), 32'(tbl[i].ctr));
            chk($sformatf("d4_ovf[%0d]", i), 32'(ovf4), 32'(tbl[i].ovf));
            chk($sformatf("d4_st[%0d]", i), 32'(st4), 32'(tbl[i].st));
            chk($sformatf("d4_cnt[%0d]", i), 32'(cnt4), tbl[i].cnt);
        end

        // Async reset mid-WAIT at cnt=2 with o_CTR=1
        repeat (4) @(negedge clk_slow);
        chk("pre_rst_cnt", 32'(cnt4), 2);
        chk("pre_rst_ctr", 32'(ctr4), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ctr", 32'(ctr4), 0);
        chk("async_rst_cnt", 32'(cnt4), 0);
        chk("async_rst_st", 32'(st4), 0);
        chk("async_rst_ovf", 32'(ovf4), 0);
        @(negedge clk_slow);
        rst = 1'b0;
        edges_to_toggle(0, 20, n);
        chk("post_rst_first_toggle", n, 6);
        chk("post_rst_ctr", 32'(ctr4), 1);

        // Illegal state 2'b11 recovers to ST_RST with o_CTR held and counter cleared
        @(negedge clk_slow);
        force dut4.state_q = 2'b11;
        #1;
        chk("illegal_ovf", 32'(ovf4), 0);
        release dut4.state_q;
        c_hold = ctr4;
        @(posedge clk_slow);
        #1;
        chk("illegal_next_st", 32'(st4), 0);
        chk("illegal_next_cnt", 32'(cnt4), 0);
        chk("illegal_ctr_held", 32'(ctr4), 32'(c_hold));
        edges_to_toggle(0, 20, n);
        chk("illegal_resume_first", n, 6);
        edges_to_toggle(0, 20, n);
        chk("illegal_resume_period", n, 7);

        // DELAY_TIME=0: states 01,10,00 repeating, toggles on edges 2,5,8
        do_reset();
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk_slow);
            exp_st = (e % 3 == 1) ? 2'b01 : (e % 3 == 2) ? 2'b10 : 2'b00;
            chk($sformatf("d0_st[%0d]", e), 32'(st0), 32'(exp_st));
            chk($sformatf("d0_ctr[%0d]", e), 32'(ctr0), ((e + 1) / 3) % 2);
            chk($sformatf("d0_ovf[%0d]", e), 32'(ovf0), 32'(exp_st == 2'b01));
            chk($sformatf("d0_cnt[%0d]", e), 32'(cnt0), 0);
        end

        // Default DELAY_TIME=1000: first toggle edge 1002, then 1003 apart, cnt saturates at 1000
        do_reset();
        prev     = ctrd;
        first_e  = -1;
        second_e = -1;
        maxc     = 0;
        for (int e = 1; e <= 2100 && second_e < 0; e++) begin
            @(posedge clk_slow);
            #1;
            if (int'(cntd) > maxc) maxc = int'(cntd);
            if (ctrd != prev) begin
                prev = ctrd;
                if (first_e < 0) first_e = e;
                else second_e = e;
            end
        end
        chk("dflt_first_toggle", first_e, 1002);
        chk("dflt_period", second_e - first_e, 1003);
        chk("dflt_max_cnt", maxc, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
